bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master_if.sv | 46 ++++
 rtl/bus_master.sv | 189 ++++++++++++++++++
 tb/tb_bus_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if -- request side and external bus side of bus_master.
//
// Request side : REQ, REQ_RW (1=read), REQ_SIZE (1=byte), REQ_ADDR[23:0],
//                REQ_WDATA[15:0]  ->  ACK, ERR, RDATA[15:0], BUSY
// Bus side     : AS, UDS, LDS (active-high strobes), RW (1=read),
//                ADDR[23:0], DATA_OUT[15:0], DATA_OE  ->  external bus
//                DATA_IN[15:0], DTACK_IN, BERR_IN (pre-synchronised)
//
// Modports: master = the bus_master view, slave = the environment view.
// ---------------------------------------------------------------------------
interface bus_master_if;
  logic        REQ;
  logic        REQ_RW;
  logic        REQ_SIZE;
  logic [23:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        ACK;
  logic        ERR;
  logic [15:0] RDATA;
  logic        BUSY;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic [23:0] ADDR;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic [15:0] DATA_IN;
  logic        DTACK_IN;
  logic        BERR_IN;

  modport master (
    input  REQ, REQ_RW, REQ_SIZE, REQ_ADDR, REQ_WDATA,
    input  DATA_IN, DTACK_IN, BERR_IN,
    output ACK, ERR, RDATA, BUSY,
    output AS, UDS, LDS, RW, ADDR, DATA_OUT, DATA_OE
  );

  modport slave (
    output REQ, REQ_RW, REQ_SIZE, REQ_ADDR, REQ_WDATA,
    output DATA_IN, DTACK_IN, BERR_IN,
    input  ACK, ERR, RDATA, BUSY,
    input  AS, UDS, LDS, RW, ADDR, DATA_OUT, DATA_OE
  );
endinterface

// File: rtl/bus_master.sv
// ---------------------------------------------------------------------------
// bus_master -- 68000-style asynchronous bus cycle generator.
//
// Ports:
//   CPUCLK_IN  single clock, all state changes on its rising edge
//   RESET_n    asynchronous, active-low reset
//   bus        bus_master_if.master (request handshake + external bus)
//
// Cycle: IDLE -> ADDR -> ASSERT -> WAIT -> LATCH -> NEGATE -> IDLE.
// A bus error in WAIT skips LATCH; a misaligned word request goes straight
// from IDLE to NEGATE without touching the bus. All outputs are registered.
//
// Optional feature (macro BUS_MASTER_TIMEOUT_EN): an 8-bit WAIT counter that
// aborts the cycle with ERR after TIMEOUT_CYCLES WAIT cycles (2..255).
// Without the macro WAIT ends only on DTACK_IN or BERR_IN.
// ---------------------------------------------------------------------------
module bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         CPUCLK_IN,
  input  logic         RESET_n,
  bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_LATCH, S_NEGATE
  } state_e;

  state_e      state_q;
  logic        as_q, uds_q, lds_q, oe_q;
  logic        ack_q, err_q, busy_q;
  logic        rw_q;
  logic        byte_q;
  logic        uds_sel_q, lds_sel_q;
  logic [23:0] addr_q;
  logic [15:0] dout_q;
  logic [15:0] rdata_q;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge CPUCLK_IN or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= S_IDLE;
      as_q      <= 1'b0;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b1;
      byte_q    <= 1'b0;
      uds_sel_q <= 1'b0;
      lds_sel_q <= 1'b0;
      addr_q    <= 24'h0;
      dout_q    <= 16'h0;
      rdata_q   <= 16'h0;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_cnt_q <= 8'h0;
`endif
    end else begin
      // ACK/ERR are single-cycle pulses; only NEGATE entry raises them.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A stale termination from the previous slave blocks the start.
          if (bus.REQ && !bus.DTACK_IN && !bus.BERR_IN) begin
            rw_q      <= bus.REQ_RW;
            addr_q    <= bus.REQ_ADDR;
            byte_q    <= bus.REQ_SIZE;
            uds_sel_q <= !bus.REQ_SIZE || !bus.REQ_ADDR[0];
            lds_sel_q <= !bus.REQ_SIZE || bus.REQ_ADDR[0];
            // Byte writes replicate the byte so either lane carries it.
            dout_q    <= bus.REQ_SIZE ? {2{bus.REQ_WDATA[7:0]}} : bus.REQ_WDATA;
            busy_q    <= 1'b1;
            if (!bus.REQ_SIZE && bus.REQ_ADDR[0]) begin
              // Misaligned word: report an error without a bus cycle.
              state_q <= S_NEGATE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          state_q <= S_ASSERT;
          as_q    <= 1'b1;
          // Reads strobe DS with AS; writes drive data first, DS a cycle later.
          if (rw_q) begin
            uds_q <= uds_sel_q;
            lds_q <= lds_sel_q;
          end else begin
            oe_q  <= 1'b1;
          end
        end

        S_ASSERT: begin
          state_q <= S_WAIT;
          uds_q   <= uds_sel_q;
          lds_q   <= lds_sel_q;
`ifdef BUS_MASTER_TIMEOUT_EN
          tmo_cnt_q <= 8'h0;
`endif
        end

        S_WAIT: begin
          // BERR has priority over a simultaneous DTACK.
          if (bus.BERR_IN) begin
            state_q <= S_NEGATE;
            as_q    <= 1'b0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end else if (bus.DTACK_IN) begin
            state_q <= S_LATCH;
          end
`ifdef BUS_MASTER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= S_NEGATE;
            as_q    <= 1'b0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end

        S_LATCH: begin
          state_q <= S_NEGATE;
          as_q    <= 1'b0;
          uds_q   <= 1'b0;
          lds_q   <= 1'b0;
          ack_q   <= 1'b1;
          if (rw_q) begin
            // UDS carries D15..8 (even byte), LDS carries D7..0 (odd byte).
            if (!byte_q)
              rdata_q <= bus.DATA_IN;
            else if (addr_q[0])
              rdata_q <= {8'h00, bus.DATA_IN[7:0]};
            else
              rdata_q <= {8'h00, bus.DATA_IN[15:8]};
          end
        end

        S_NEGATE: begin
          // Write data stays driven through NEGATE for slave hold time.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          as_q    <= 1'b0;
          uds_q   <= 1'b0;
          lds_q   <= 1'b0;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK      = ack_q;
  assign bus.ERR      = err_q;
  assign bus.RDATA    = rdata_q;
  assign bus.BUSY     = busy_q;
  assign bus.AS       = as_q;
  assign bus.UDS      = uds_q;
  assign bus.LDS      = lds_q;
  assign bus.RW       = rw_q;
  assign bus.ADDR     = addr_q;
  assign bus.DATA_OUT = dout_q;
  assign bus.DATA_OE  = oe_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_bus_master;

  logic CPUCLK_IN = 1'b0;
  logic RESET_n   = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   bad;

  bus_master_if bus ();

  bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .CPUCLK_IN (CPUCLK_IN),
    .RESET_n   (RESET_n),
    .bus       (bus)
  );

  always #5 CPUCLK_IN = ~CPUCLK_IN;

  task automatic step();
    @(negedge CPUCLK_IN);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic rw, input logic size, input logic [23:0] addr,
                         input logic [15:0] wdata);
    bus.REQ       = 1'b1;
    bus.REQ_RW    = rw;
    bus.REQ_SIZE  = size;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
  endtask

  initial begin
    bus.REQ = 0; bus.REQ_RW = 0; bus.REQ_SIZE = 0; bus.REQ_ADDR = 0;
    bus.REQ_WDATA = 0; bus.DATA_IN = 0; bus.DTACK_IN = 0; bus.BERR_IN = 0;

    // Reset state
    step(); step();
    chk("rst_as",    {31'd0, bus.AS}, 32'd0);
    chk("rst_busy",  {31'd0, bus.BUSY}, 32'd0);
    chk("rst_ack",   {31'd0, bus.ACK}, 32'd0);
    chk("rst_rw",    {31'd0, bus.RW}, 32'd1);
    chk("rst_addr",  {8'd0, bus.ADDR}, 32'd0);
    chk("rst_dout",  {16'd0, bus.DATA_OUT}, 32'd0);
    chk("rst_rdata", {16'd0, bus.RDATA}, 32'd0);

    // Word read 0x000100, accepted on the first edge after reset release
    RESET_n = 1'b1;
    request(1'b1, 1'b0, 24'h000100, 16'h0);
    bus.DATA_IN = 16'hBEEF;
    step(); // ADDR
    chk("wr_addr_busy", {31'd0, bus.BUSY}, 32'd1);
    chk("wr_addr_as",   {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'd0);
    chk("wr_addr_bus",  {8'd0, bus.ADDR}, 32'h000100);
    chk("wr_addr_rw",   {31'd0, bus.RW}, 32'd1);
    bus.REQ = 1'b0; bus.DTACK_IN = 1'b1;
    step(); // ASSERT
    chk("rd_assert_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'b111);
    chk("rd_assert_oe",   {31'd0, bus.DATA_OE}, 32'd0);
    step(); // WAIT
    chk("rd_wait_ack", {31'd0, bus.ACK}, 32'd0);
    step(); // LATCH
    chk("rd_latch_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'b111);
    chk("rd_latch_ack",  {31'd0, bus.ACK}, 32'd0);
    step(); // NEGATE: edge k+4
    chk("rd_ack",   {30'd0, bus.ACK, bus.ERR}, 32'b10);
    chk("rd_rdata", {16'd0, bus.RDATA}, 32'hBEEF);
    chk("rd_neg_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'd0);
    bus.DTACK_IN = 1'b0;
    step(); // IDLE
    chk("rd_idle", {30'd0, bus.ACK, bus.BUSY}, 32'd0);

    // Byte write 0x000201 data 0x00A5, DTACK after 3 WAIT cycles
    request(1'b0, 1'b1, 24'h000201, 16'h00A5);
    step(); // ADDR
    bus.REQ = 1'b0;
    chk("bw_dout", {16'd0, bus.DATA_OUT}, 32'hA5A5);
    chk("bw_rw",   {31'd0, bus.RW}, 32'd0);
    chk("bw_addr_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'd0);
    step(); // ASSERT
    chk("bw_assert", {28'd0, bus.AS, bus.UDS, bus.LDS, bus.DATA_OE}, 32'b1001);
    step(); // WAIT 1
    chk("bw_wait", {28'd0, bus.AS, bus.UDS, bus.LDS, bus.DATA_OE}, 32'b1011);
    step(); // WAIT 2
    step(); // WAIT 3
    chk("bw_wait3", {30'd0, bus.AS, bus.ACK}, 32'b10);
    bus.DTACK_IN = 1'b1;
    step(); // LATCH
    chk("bw_latch", {29'd0, bus.LDS, bus.UDS, bus.ACK}, 32'b100);
    step(); // NEGATE
    chk("bw_ack",   {30'd0, bus.ACK, bus.ERR}, 32'b10);
    chk("bw_neg",   {28'd0, bus.AS, bus.UDS, bus.LDS, bus.DATA_OE}, 32'b0001);
    chk("bw_rdata", {16'd0, bus.RDATA}, 32'hBEEF);
    bus.DTACK_IN = 1'b0;
    step(); // IDLE
    chk("bw_idle_oe", {30'd0, bus.DATA_OE, bus.BUSY}, 32'd0);

    // Word read with DTACK and BERR together: BERR wins
    request(1'b1, 1'b0, 24'h000400, 16'h0);
    bus.DATA_IN = 16'h1234;
    step(); // ADDR
    bus.REQ = 1'b0; bus.DTACK_IN = 1'b1; bus.BERR_IN = 1'b1;
    step(); // ASSERT
    step(); // WAIT
    step(); // NEGATE
    chk("berr_ack",   {30'd0, bus.ACK, bus.ERR}, 32'b11);
    chk("berr_rdata", {16'd0, bus.RDATA}, 32'hBEEF);
    chk("berr_strb",  {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'd0);
    bus.DTACK_IN = 1'b0; bus.BERR_IN = 1'b0;
    step(); // IDLE

    // Misaligned word request: no bus cycle
    request(1'b1, 1'b0, 24'h000003, 16'h0);
    step(); // NEGATE directly
    bus.REQ = 1'b0;
    chk("mis_ack",  {30'd0, bus.ACK, bus.ERR}, 32'b11);
    chk("mis_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'd0);
    chk("mis_busy", {31'd0, bus.BUSY}, 32'd1);
    step(); // IDLE
    chk("mis_idle", {29'd0, bus.AS, bus.ACK, bus.BUSY}, 32'd0);

    // Request held pending by DTACK, then byte read of the even (upper) byte
    request(1'b1, 1'b1, 24'h000300, 16'h0);
    bus.DTACK_IN = 1'b1;
    bus.DATA_IN  = 16'h5AC3;
    step();
    step();
    chk("pend_busy", {31'd0, bus.BUSY}, 32'd0);
    bus.DTACK_IN = 1'b0;
    step(); // ADDR
    chk("pend_accept", {31'd0, bus.BUSY}, 32'd1);
    bus.REQ = 1'b0; bus.DTACK_IN = 1'b1;
    step(); // ASSERT
    chk("br_strb", {29'd0, bus.AS, bus.UDS, bus.LDS}, 32'b110);
    step(); // WAIT
    step(); // LATCH
    step(); // NEGATE
    chk("br_ack",   {30'd0, bus.ACK, bus.ERR}, 32'b10);
    chk("br_rdata", {16'd0, bus.RDATA}, 32'h005A);
    bus.DTACK_IN = 1'b0;
    step(); // IDLE

    // No termination: timeout abort, or indefinite WAIT without the feature
    request(1'b1, 1'b0, 24'h000500, 16'h0);
    step(); // ADDR
    bus.REQ = 1'b0;
    step(); // ASSERT
`ifdef BUS_MASTER_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step(); // WAIT cycle i+1
      if (bus.AS !== 1'b1 || bus.ACK !== 1'b0) bad++;
    end
    chk("tmo_wait16", bad, 0);
    step(); // NEGATE
    chk("tmo_ack", {30'd0, bus.ACK, bus.ERR}, 32'b11);
    step(); // IDLE
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.AS !== 1'b1 || bus.ACK !== 1'b0) bad++;
    end
    chk("notmo_wait", bad, 0);
    chk("notmo_busy", {31'd0, bus.BUSY}, 32'd1);
    bus.BERR_IN = 1'b1;
    step(); // NEGATE
    chk("notmo_berr", {30'd0, bus.ACK, bus.ERR}, 32'b11);
    bus.BERR_IN = 1'b0;
    step(); // IDLE
`endif

    // Reset asserted mid-cycle during WAIT of a write
    request(1'b0, 1'b0, 24'h000600, 16'h1357);
    step(); // ADDR
    bus.REQ = 1'b0;
    step(); // ASSERT
    step(); // WAIT
    chk("rw_wait", {28'd0, bus.AS, bus.UDS, bus.LDS, bus.DATA_OE}, 32'b1111);
    #2 RESET_n = 1'b0;
    #1;
    chk("rw_async_strb", {28'd0, bus.AS, bus.UDS, bus.LDS, bus.DATA_OE}, 32'd0);
    chk("rw_async_ctl",  {30'd0, bus.BUSY, bus.ACK}, 32'd0);
    chk("rw_async_rd",   {16'd0, bus.RDATA}, 32'd0);
    step();
    step();
    chk("rw_no_ack", {31'd0, bus.ACK}, 32'd0);

    // Normal cycle after reset release
    RESET_n = 1'b1;
    request(1'b1, 1'b0, 24'h000700, 16'h0);
    bus.DATA_IN = 16'h2468;
    step(); // ADDR
    bus.REQ = 1'b0; bus.DTACK_IN = 1'b1;
    step(); // ASSERT
    step(); // WAIT
    step(); // LATCH
    step(); // NEGATE
    chk("post_ack",   {30'd0, bus.ACK, bus.ERR}, 32'b10);
    chk("post_rdata", {16'd0, bus.RDATA}, 32'h2468);
    bus.DTACK_IN = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
